// File: rtl/ex_muldiv_stage.sv
// RV32M multiply/divide execute stage: operand forwarding, sign handling and a
// sequential radix-2 multiplier / restoring divider behind a valid/ready handshake.
module ex_muldiv_stage #(
    parameter int XLEN = 32,
    parameter int NUM_FWD = 2,
    localparam int SELW = $clog2(NUM_FWD + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [XLEN-1:0]         in_rs1_data,
    input  logic [XLEN-1:0]         in_rs2_data,
    input  logic [SELW-1:0]         fwd_sel_a,
    input  logic [SELW-1:0]         fwd_sel_b,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic [4:0]              in_rd_addr,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_result,
    output logic [4:0]              out_rd_addr,
    output logic                    busy
);
    localparam int CNTW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;

    logic [XLEN-1:0]     opA, opB, magA, magB;
    logic                signedA, signedB, negA, negB;
    logic                divZero, divOvf;
    logic [XLEN:0]       mulSum, remShift;
    logic [XLEN-1:0]     remDiff;
    logic                remGe;
    logic [2*XLEN-1:0]   accStep, prod;
    logic [XLEN-1:0]     quo, rem, finalRes;

    always_comb begin
        opA = in_rs1_data;
        opB = in_rs2_data;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (int'(fwd_sel_a) == k) opA = fwd_data[(k-1)*XLEN +: XLEN];
            if (int'(fwd_sel_b) == k) opB = fwd_data[(k-1)*XLEN +: XLEN];
        end
        signedA = (in_op != 3'd3) && (in_op != 3'd5) && (in_op != 3'd7);
        signedB = signedA && (in_op != 3'd2);
        negA    = signedA && opA[XLEN-1];
        negB    = signedB && opB[XLEN-1];
        magA    = negA ? -opA : opA;
        magB    = negB ? -opB : opB;
        divZero = in_op[2] && (opB == '0);
        divOvf  = in_op[2] && !in_op[0] && (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1);
    end

    // One iteration: the accumulator low half holds the multiplier / dividend bits
    // still to be consumed, the high half the partial product / partial remainder.
    always_comb begin
        mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
        remShift = acc_q[2*XLEN-1:XLEN-1];
        remGe    = remShift >= {1'b0, opb_q};
        remDiff  = remShift[XLEN-1:0] - opb_q;
        if (op_q[2])
            accStep = remGe ? {remDiff, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
        else
            accStep = {mulSum, acc_q[XLEN-1:1]};

        prod = negq_q ? -accStep : accStep;
        quo  = accStep[XLEN-1:0];
        rem  = accStep[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:    finalRes = prod[XLEN-1:0];
            3'd4:    finalRes = negq_q ? -quo : quo;
            3'd5:    finalRes = quo;
            3'd6:    finalRes = negr_q ? -rem : rem;
            3'd7:    finalRes = rem;
            default: finalRes = prod[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        in_ready = (state_q == IDLE) && !flush;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d   = in_op;
                        rd_d   = in_rd_addr;
                        cnt_d  = '0;
                        acc_d  = {{XLEN{1'b0}}, magA};
                        opb_d  = magB;
                        negq_d = negA ^ negB;
                        negr_d = negA;
                        if (divZero) begin
                            result_d = in_op[1] ? opA : {XLEN{1'b1}};
                            state_d  = DONE;
                        end else if (divOvf) begin
                            result_d = in_op[1] ? {XLEN{1'b0}} : opA;
                            state_d  = DONE;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = accStep;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNTW'(XLEN - 1)) begin
                        result_d = finalRes;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
        end
    end

    assign out_valid   = (state_q == DONE);
    assign out_result  = result_q;
    assign out_rd_addr = rd_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Scoreboard bench for ex_muldiv_stage: issued operations push the reference
// result and expected ready cycle; a monitor pops and compares on out_valid.
module tb_ex_muldiv_stage;
    localparam int XLEN = 32;
    localparam int NUM_FWD = 2;
    localparam int SELW = $clog2(NUM_FWD + 1);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [2:0]              in_op = '0;
    logic [XLEN-1:0]         in_rs1_data = '0;
    logic [XLEN-1:0]         in_rs2_data = '0;
    logic [SELW-1:0]         fwd_sel_a = '0;
    logic [SELW-1:0]         fwd_sel_b = '0;
    logic [NUM_FWD*XLEN-1:0] fwd_data = '0;
    logic [4:0]              in_rd_addr = '0;
    logic                    flush = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [XLEN-1:0]         out_result;
    logic [4:0]              out_rd_addr;
    logic                    busy;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        int          readyCyc;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;
    bit   haveCur = 1'b0;
    bit   randReady = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    ex_muldiv_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .fwd_data(fwd_data),
        .in_rd_addr(in_rd_addr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_rd_addr(out_rd_addr),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference results straight from the RV32M definitions using wide arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pickOperand(input logic [SELW-1:0] sel, input logic [31:0] rs, input logic [63:0] fwd);
        if (sel == 1) return fwd[31:0];
        if (sel == 2) return fwd[63:32];
        return rs;
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [SELW-1:0] selA, input logic [SELW-1:0] selB,
                                 input logic [63:0] fwd, input logic [4:0] rd);
        bit ok;
        logic [31:0] a, b;
        bit special;
        exp_t e;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("[TB] FAIL issueTimeout: in_ready got 0 expected 1");
            return;
        end
        in_op = op; in_rs1_data = rs1; in_rs2_data = rs2;
        fwd_sel_a = selA; fwd_sel_b = selB; fwd_data = fwd; in_rd_addr = rd;
        in_valid = 1'b1;
        a = pickOperand(selA, rs1, fwd);
        b = pickOperand(selB, rs2, fwd);
        special = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        e.result = refModel(op, a, b);
        e.rd = rd;
        e.readyCyc = cyc + (special ? 1 : XLEN + 1);
        expQ.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 3000; n++) begin
            if (expQ.size() == 0 && !haveCur && !busy) return;
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("[TB] FAIL drainTimeout: pending got %0d expected 0", expQ.size());
    endtask

    task automatic checkNoValid(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checkOutput(name, 64'(seen), 64'd0);
    endtask

    // Monitor: first valid cycle pops and checks latency; every valid cycle checks the held output.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!haveCur) begin
                if (expQ.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL unexpectedValid: out_valid got 1 expected 0");
                end else begin
                    cur = expQ.pop_front();
                    haveCur = 1'b1;
                    checkOutput("latency", 64'(cyc), 64'(cur.readyCyc));
                end
            end
            if (haveCur) begin
                checkOutput("result", 64'(out_result), 64'(cur.result));
                checkOutput("rdAddr", 64'(out_rd_addr), 64'(cur.rd));
                if (out_ready) haveCur = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        logic [2:0] op;
        logic [SELW-1:0] sa, sb;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetValid", 64'(out_valid), 64'd0);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetResult", 64'(out_result), 64'd0);
        checkOutput("resetRd", 64'(out_rd_addr), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("releaseReady", 64'(in_ready), 64'd1);
        checkOutput("releaseBusy", 64'(busy), 64'd0);

        $display("[TB] directed operations");
        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0, 64'h0, 5'd1);
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 64'h0, 5'd2);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 64'h0, 5'd3);
        applyStimulus(3'd5, 32'd100, 32'd0, 0, 0, 64'h0, 5'd4);
        applyStimulus(3'd7, 32'd100, 32'd0, 0, 0, 64'h0, 5'd5);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 64'h0, 5'd6);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 64'h0, 5'd7);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, 64'h0, 5'd8);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, 64'h0, 5'd9);
        applyStimulus(3'd5, 32'd1234, 32'd3, 2, 0, {32'd9, 32'd77}, 5'd10);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd0, 3, 1, {32'd1, 32'd5}, 5'd11);
        waitDrain();

        $display("[TB] output hold");
        out_ready = 1'b0;
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, 64'h0, 5'd13);
        for (int n = 0; n < 100 && !out_valid; n++) begin @(posedge clk); #1; end
        repeat (5) @(posedge clk);
        #1;
        checkOutput("holdValid", 64'(out_valid), 64'd1);
        checkOutput("holdBusy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("handshakeValid", 64'(out_valid), 64'd0);
        checkOutput("handshakeReady", 64'(in_ready), 64'd1);
        checkOutput("handshakeBusy", 64'(busy), 64'd0);

        $display("[TB] flush in CALC");
        applyStimulus(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 64'h0, 5'd14);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        checkOutput("flushReady", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        void'(expQ.pop_back());
        checkOutput("flushBusy", 64'(busy), 64'd0);
        checkNoValid("noValidAfterFlush", 40);

        $display("[TB] flush with in_valid in IDLE");
        flush = 1'b1; in_valid = 1'b1; in_op = 3'd0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checkOutput("flushNoAccept", 64'(busy), 64'd0);
        checkNoValid("noValidIdleFlush", 5);

        $display("[TB] reset mid-CALC");
        applyStimulus(3'd5, 32'hFFFF_0000, 32'd7, 0, 0, 64'h0, 5'd15);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetValid", 64'(out_valid), 64'd0);
        checkOutput("midResetResult", 64'(out_result), 64'd0);
        checkOutput("midResetRd", 64'(out_rd_addr), 64'd0);
        checkOutput("midResetBusy", 64'(busy), 64'd0);
        void'(expQ.pop_back());
        haveCur = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("postResetReady", 64'(in_ready), 64'd1);
        checkNoValid("noValidAfterReset", 40);

        $display("[TB] randomized operations");
        randReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            sa = SELW'($urandom_range(0, 3));
            sb = SELW'($urandom_range(0, 3));
            applyStimulus(op, randOperand(), randOperand(), sa, sb,
                          {randOperand(), randOperand()}, 5'($urandom_range(0, 31)));
        end
        randReady = 1'b0;
        out_ready = 1'b1;
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
